vec_cmd_issuer: RTL and testbench

- Host-side initiator for the vector accelerator command interface. It is the master that drives op/addr/scalar/data plus the valid strobe, and consumes done, read data and ready.
- Buffers host commands in a small FIFO and issues them one at a time, keeping exactly one operation in flight.
- For read operations it captures the returned vector and presents it to the host through a valid/yumi response port.

---
 rtl/vec_cmd_issuer_if.sv | 30 +++
 rtl/vec_cmd_issuer.sv | 205 ++++++++++++++++++++
 tb/tb_vec_cmd_issuer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_cmd_issuer_if.sv
// Command bus between the host-side issuer (master) and the vector accelerator (slave).
// Field names match the issuer's accelerator-facing signal names.
interface vec_cmd_issuer_if #(
  parameter int aw_p = 3,   // vector register address width
  parameter int vw_p = 16   // vector width in bits
) ();
  logic [3:0]      acc_op_o;
  logic [aw_p-1:0] acc_addrA_o;
  logic [aw_p-1:0] acc_addrB_o;
  logic [aw_p-1:0] acc_addrC_o;
  logic [vw_p-1:0] acc_scalar_o;
  logic [vw_p-1:0] acc_wdata_o;
  logic            acc_v_o;
  logic            acc_ready_i;
  logic            acc_done_i;
  logic [vw_p-1:0] acc_rdata_i;
  logic            acc_yumi_o;

  modport master (
    output acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_scalar_o, acc_wdata_o,
    output acc_v_o, acc_yumi_o,
    input  acc_ready_i, acc_done_i, acc_rdata_i
  );

  modport slave (
    input  acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrC_o, acc_scalar_o, acc_wdata_o,
    input  acc_v_o, acc_yumi_o,
    output acc_ready_i, acc_done_i, acc_rdata_i
  );
endinterface

// File: rtl/vec_cmd_issuer.sv
// vec_cmd_issuer: buffers host commands in a small FIFO and issues them to the
// vector accelerator one at a time, with exactly one operation in flight. Read
// results are captured and handed to the host over a valid/yumi response port.
// Optional feature macro: VEC_ISSUE_TIMEOUT_EN (WAIT watchdog; off by default).
module vec_cmd_issuer #(
  parameter  int els_p            = 8,
  parameter  int vlen_p           = 4,
  parameter  int vdw_p            = 4,
  parameter  int fifo_els_p       = 4,
  parameter  int timeout_cycles_p = 64,
  localparam int aw_lp            = (els_p == 1) ? 1 : $clog2(els_p),
  localparam int vw_lp            = vlen_p * vdw_p
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  // host command port
  input  logic              cmd_v_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [aw_lp-1:0]  cmd_addrA_i,
  input  logic [aw_lp-1:0]  cmd_addrB_i,
  input  logic [aw_lp-1:0]  cmd_addrC_i,
  input  logic [vw_lp-1:0]  cmd_scalar_i,
  input  logic [vw_lp-1:0]  cmd_wdata_i,
  // accelerator command bus
  vec_cmd_issuer_if.master  acc,
  // host response port
  output logic              resp_v_o,
  output logic [vw_lp-1:0]  resp_data_o,
  input  logic              resp_yumi_i,
  // status
  output logic              busy_o,
  output logic              illegal_o
);

  localparam int pw_lp = $clog2(fifo_els_p);

  localparam logic [3:0] OP_READ = 4'b1000;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef struct packed {
    logic [3:0]       op;
    logic [aw_lp-1:0] a;
    logic [aw_lp-1:0] b;
    logic [aw_lp-1:0] c;
    logic [vw_lp-1:0] scalar;
    logic [vw_lp-1:0] wdata;
  } cmd_t;

  // Legal: write 1001, read 1000, vector/scalar ALU {0x,f} with f != 11.
  function automatic logic op_legal(input logic [3:0] op);
    if (!op[3]) return (op[1:0] != 2'b11);
    else        return (op[2:1] == 2'b00);
  endfunction

  // ---------------- command FIFO ----------------
  cmd_t             r_mem [fifo_els_p];
  logic [pw_lp:0]   r_wr_ptr, r_rd_ptr;   // extra MSB distinguishes full from empty
  logic             r_live;               // holds cmd_ready_o low until after reset release
  logic             w_empty, w_full, w_enq, w_deq;
  cmd_t             w_cmd_in, w_head;
  logic             w_head_legal;

  logic [2:0]       r_state, w_state_nxt;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[pw_lp] != r_rd_ptr[pw_lp]) &&
                    (r_wr_ptr[pw_lp-1:0] == r_rd_ptr[pw_lp-1:0]);
  assign cmd_ready_o = r_live & ~w_full;
  assign w_enq    = cmd_v_i & cmd_ready_o;
  assign w_deq    = (r_state == ST_ISSUE);   // ISSUE is only entered with a non-empty FIFO

  assign w_cmd_in = '{op: cmd_op_i, a: cmd_addrA_i, b: cmd_addrB_i, c: cmd_addrC_i,
                      scalar: cmd_scalar_i, wdata: cmd_wdata_i};
  assign w_head       = r_mem[r_rd_ptr[pw_lp-1:0]];
  assign w_head_legal = op_legal(w_head.op);

  // Ready-enable comes up one cycle after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_live <= 1'b0;
    else            r_live <= 1'b1;
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr[pw_lp-1:0]] <= w_cmd_in;
  end

  // FIFO pointers, wrapping naturally modulo 2*fifo_els_p.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------- issue FSM ----------------
  logic [3:0]       r_op;
  logic [aw_lp-1:0] r_a, r_b, r_c;
  logic [vw_lp-1:0] r_scalar, r_wdata, r_resp_data;
  logic             r_acc_v, r_illegal;
  logic             w_is_rd, w_done_wait, w_timeout;

  assign w_is_rd     = (r_op == OP_READ);
  assign w_done_wait = (r_state == ST_WAIT) & acc.acc_done_i;

`ifdef VEC_ISSUE_TIMEOUT_EN
  localparam int tw_lp = $clog2(timeout_cycles_p + 1);
  logic [tw_lp-1:0] r_to_cnt;

  // Watchdog fires at the end of the timeout_cycles_p-th WAIT cycle without done.
  assign w_timeout = (r_state == ST_WAIT) & ~acc.acc_done_i &
                     (r_to_cnt == tw_lp'(timeout_cycles_p - 1));

  // Count cycles spent in WAIT; cleared everywhere else.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)              r_to_cnt <= '0;
    else if (r_state == ST_WAIT) r_to_cnt <= r_to_cnt + 1'b1;
    else                         r_to_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_empty && acc.acc_ready_i) w_state_nxt = ST_ISSUE;
      ST_ISSUE:  w_state_nxt = w_head_legal ? ST_STROBE : ST_IDLE;
      ST_STROBE: w_state_nxt = ST_WAIT;
      ST_WAIT:   if (acc.acc_done_i || w_timeout) w_state_nxt = w_is_rd ? ST_RESP : ST_IDLE;
      ST_RESP:   if (resp_yumi_i) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Command fields latch in ISSUE (legal ops only) and stay stable through WAIT.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_scalar <= '0;
      r_wdata  <= '0;
    end else if (r_state == ST_ISSUE && w_head_legal) begin
      r_op     <= w_head.op;
      r_a      <= w_head.a;
      r_b      <= w_head.b;
      r_c      <= w_head.c;
      r_scalar <= w_head.scalar;
      r_wdata  <= w_head.wdata;
    end
  end

  // One-cycle strobe: high exactly while the FSM sits in STROBE.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_acc_v <= 1'b0;
    else            r_acc_v <= (r_state == ST_ISSUE) & w_head_legal;
  end

  // Read data capture; a timed-out read reports zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                    r_resp_data <= '0;
    else if (w_done_wait && w_is_rd)   r_resp_data <= acc.acc_rdata_i;
    else if (w_timeout && w_is_rd)     r_resp_data <= '0;
  end

  // Sticky error flag: illegal opcode popped, or watchdog expiry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                     r_illegal <= 1'b0;
    else if ((r_state == ST_ISSUE && !w_head_legal) ||
             w_timeout)                                 r_illegal <= 1'b1;
  end

  assign acc.acc_op_o     = r_op;
  assign acc.acc_addrA_o  = r_a;
  assign acc.acc_addrB_o  = r_b;
  assign acc.acc_addrC_o  = r_c;
  assign acc.acc_scalar_o = r_scalar;
  assign acc.acc_wdata_o  = r_wdata;
  assign acc.acc_v_o      = r_acc_v;
  assign acc.acc_yumi_o   = w_done_wait & w_is_rd;

  assign resp_v_o    = (r_state == ST_RESP);
  assign resp_data_o = r_resp_data;
  assign busy_o      = ~w_empty | (r_state != ST_IDLE);
  assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Directed bench for vec_cmd_issuer with a small behavioural accelerator
// (register file, fixed two-cycle latency) on the slave side of the bus.
module tb_vec_cmd_issuer;
  localparam int AW = 3;
  localparam int VW = 16;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          cmd_v_i = 1'b0;
  logic          cmd_ready_o;
  logic [3:0]    cmd_op_i = '0;
  logic [AW-1:0] cmd_addrA_i = '0, cmd_addrB_i = '0, cmd_addrC_i = '0;
  logic [VW-1:0] cmd_scalar_i = '0, cmd_wdata_i = '0;
  logic          resp_v_o;
  logic [VW-1:0] resp_data_o;
  logic          resp_yumi_i = 1'b0;
  logic          busy_o, illegal_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  vec_cmd_issuer_if #(.aw_p(AW), .vw_p(VW)) acc_if ();

  vec_cmd_issuer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addrA_i(cmd_addrA_i), .cmd_addrB_i(cmd_addrB_i), .cmd_addrC_i(cmd_addrC_i),
    .cmd_scalar_i(cmd_scalar_i), .cmd_wdata_i(cmd_wdata_i),
    .acc(acc_if),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .busy_o(busy_o), .illegal_o(illegal_o)
  );

  // ---------------- accelerator model ----------------
  logic [VW-1:0] rf [8];
  int            pend = 0;
  bit            stuck = 1'b0;
  int            strobes = 0, yumis = 0;
  logic [VW-1:0] wd_log [$];
  logic [3:0]    m_op = '0;
  logic [AW-1:0] m_a, m_b, m_c;
  logic [VW-1:0] m_s, m_wd;

  function automatic logic [VW-1:0] alu(input logic [1:0] f, input logic [VW-1:0] x,
                                        input logic [VW-1:0] y);
    logic [VW-1:0] r;
    r = '0;
    for (int e = 0; e < 4; e++)
      case (f)
        2'b00:   r[e*4 +: 4] = x[e*4 +: 4] + y[e*4 +: 4];
        2'b01:   r[e*4 +: 4] = x[e*4 +: 4] - y[e*4 +: 4];
        2'b10:   r[e*4 +: 4] = x[e*4 +: 4] * y[e*4 +: 4];
        default: r[e*4 +: 4] = '0;
      endcase
    return r;
  endfunction

  initial begin
    acc_if.acc_ready_i = 1'b1;
    acc_if.acc_done_i  = 1'b0;
    acc_if.acc_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      acc_if.acc_done_i = 1'b0;
      if (!stuck && pend > 0) begin
        pend--;
        if (pend == 0) begin
          case (m_op)
            4'b1001: rf[m_c] = m_wd;
            4'b1000: acc_if.acc_rdata_i = rf[m_a];
            default: rf[m_c] = m_op[2] ? alu(m_op[1:0], rf[m_a], m_s)
                                       : alu(m_op[1:0], rf[m_a], rf[m_b]);
          endcase
          acc_if.acc_done_i = 1'b1;
          #1 if (acc_if.acc_yumi_o) yumis++;
        end
      end
      if (acc_if.acc_v_o) begin
        m_op = acc_if.acc_op_o;   m_a = acc_if.acc_addrA_o; m_b = acc_if.acc_addrB_o;
        m_c = acc_if.acc_addrC_o; m_s = acc_if.acc_scalar_o; m_wd = acc_if.acc_wdata_o;
        wd_log.push_back(m_wd);
        strobes++;
        pend = 2;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- host-side helpers ----------------
  task automatic send(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] c, input logic [VW-1:0] s, input logic [VW-1:0] wd);
    int t = 0;
    @(negedge clk_i);
    cmd_v_i = 1'b1; cmd_op_i = op; cmd_addrA_i = a; cmd_addrB_i = b; cmd_addrC_i = c;
    cmd_scalar_i = s; cmd_wdata_i = wd;
    while (!cmd_ready_o && t < 300) begin @(negedge clk_i); t++; end
    if (t >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout op=%b cmd_ready_o never rose", op);
    end
    @(negedge clk_i);
    cmd_v_i = 1'b0;
  endtask

  task automatic get_resp(output logic [VW-1:0] d, output bit ok);
    int t = 0;
    ok = 1'b0; d = '0;
    @(negedge clk_i);
    while (!resp_v_o && t < 300) begin @(negedge clk_i); t++; end
    if (resp_v_o) begin
      ok = 1'b1; d = resp_data_o;
      resp_yumi_i = 1'b1;
      @(negedge clk_i);
      resp_yumi_i = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    @(negedge clk_i);
    while (busy_o && t < 300) begin @(negedge clk_i); t++; end
    ok = !busy_o;
  endtask

  task automatic wait_strobe(output bit ok);
    int t = 0;
    while (!acc_if.acc_v_o && t < 50) begin @(negedge clk_i); t++; end
    ok = acc_if.acc_v_o;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] flags;
    logic [3*VW+4-1:0] fields;
    bit ok;
    #1 reset_n_i = 1'b0;
    #2;
    flags = {cmd_ready_o, busy_o, illegal_o, resp_v_o, acc_if.acc_v_o, acc_if.acc_yumi_o};
    n_chk++; if (flags !== 6'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=000000", flags); end
    @(negedge clk_i); reset_n_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_release ready=%b busy=%b exp ready=1 busy=0", cmd_ready_o, busy_o);
    end
    // Abort an operation parked in WAIT.
    stuck = 1'b1;
    send(4'b1001, 3'd0, 3'd0, 3'd1, 16'h0, 16'h0101);
    wait_strobe(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL reset_strobe acc_v_o=0 exp=1"); end
    @(negedge clk_i); @(negedge clk_i);
    n_chk++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_inwait busy=%b exp=1", busy_o); end
    reset_n_i = 1'b0;
    #1;
    flags  = {cmd_ready_o, busy_o, illegal_o, resp_v_o, acc_if.acc_v_o, acc_if.acc_yumi_o};
    fields = {acc_if.acc_op_o, acc_if.acc_wdata_o, acc_if.acc_scalar_o, resp_data_o};
    n_chk++; if (flags !== 6'b0) begin n_fail++; $display("FAIL reset_midwait_flags got=%b exp=000000", flags); end
    n_chk++; if (fields !== '0) begin n_fail++; $display("FAIL reset_midwait_fields got=%h exp=0", fields); end
    pend = 0; stuck = 1'b0;
    @(negedge clk_i); reset_n_i = 1'b1;
    @(negedge clk_i);
    n_chk++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_rerelease ready=%b busy=%b exp ready=1 busy=0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_latency();
    bit ok;
    @(negedge clk_i);
    cmd_v_i = 1'b1; cmd_op_i = 4'b1001; cmd_addrC_i = 3'd6; cmd_wdata_i = 16'h6666;
    @(negedge clk_i); cmd_v_i = 1'b0;
    n_chk++; if (acc_if.acc_v_o !== 1'b0) begin n_fail++; $display("FAIL lat_c1 acc_v=%b exp=0", acc_if.acc_v_o); end
    @(negedge clk_i);
    n_chk++; if (acc_if.acc_v_o !== 1'b0) begin n_fail++; $display("FAIL lat_c2 acc_v=%b exp=0", acc_if.acc_v_o); end
    @(negedge clk_i);
    n_chk++; if (acc_if.acc_v_o !== 1'b1 || acc_if.acc_op_o !== 4'b1001 || acc_if.acc_wdata_o !== 16'h6666) begin
      n_fail++; $display("FAIL lat_c3 acc_v=%b op=%b wd=%h exp 1/1001/6666",
                         acc_if.acc_v_o, acc_if.acc_op_o, acc_if.acc_wdata_o);
    end
    @(negedge clk_i);
    n_chk++; if (acc_if.acc_v_o !== 1'b0) begin n_fail++; $display("FAIL lat_c4 acc_v=%b exp=0", acc_if.acc_v_o); end
    wait_idle(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL lat_idle busy_o stuck high"); end
  endtask

  task automatic test_vector_ops();
    int s0, y0;
    logic [VW-1:0] d;
    bit ok;
    s0 = strobes; y0 = yumis;
    send(4'b1001, 3'd0, 3'd0, 3'd1, 16'h0, 16'h0101);
    send(4'b1001, 3'd0, 3'd0, 3'd2, 16'h0, 16'h1144);
    send(4'b0000, 3'd1, 3'd2, 3'd0, 16'h0, 16'h0);
    send(4'b1000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);
    get_resp(d, ok);
    n_chk++; if (!ok || d !== 16'h1245) begin n_fail++; $display("FAIL vadd got=%h ok=%0d exp=1245", d, ok); end
    n_chk++; if (resp_v_o !== 1'b0) begin n_fail++; $display("FAIL resp_drop resp_v=%b exp=0", resp_v_o); end
    send(4'b0001, 3'd2, 3'd1, 3'd3, 16'h0, 16'h0);
    send(4'b1000, 3'd3, 3'd0, 3'd0, 16'h0, 16'h0);
    get_resp(d, ok);
    n_chk++; if (!ok || d !== 16'h1043) begin n_fail++; $display("FAIL vsub got=%h ok=%0d exp=1043", d, ok); end
    send(4'b0010, 3'd1, 3'd3, 3'd5, 16'h0, 16'h0);
    send(4'b1000, 3'd5, 3'd0, 3'd0, 16'h0, 16'h0);
    get_resp(d, ok);
    n_chk++; if (!ok || d !== 16'h0003) begin n_fail++; $display("FAIL vmul got=%h ok=%0d exp=0003", d, ok); end
    wait_idle(ok);
    n_chk++; if (strobes - s0 != 8) begin n_fail++; $display("FAIL vec_strobes got=%0d exp=8", strobes - s0); end
    n_chk++; if (yumis - y0 != 3) begin n_fail++; $display("FAIL vec_yumis got=%0d exp=3", yumis - y0); end
  endtask

  task automatic test_scalar();
    logic [VW-1:0] d;
    bit ok;
    send(4'b0100, 3'd1, 3'd0, 3'd4, 16'h1111, 16'h0);
    send(4'b1000, 3'd4, 3'd0, 3'd0, 16'h0, 16'h0);
    get_resp(d, ok);
    n_chk++; if (!ok || d !== 16'h1212) begin n_fail++; $display("FAIL sadd got=%h ok=%0d exp=1212", d, ok); end
  endtask

  task automatic test_fifo_full();
    int s0;
    bit ok;
    wait_idle(ok);
    acc_if.acc_ready_i = 1'b0;
    s0 = strobes;
    wd_log.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_chk++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL fifo_ready%0d got=%b exp=1", i, cmd_ready_o); end
      cmd_v_i = 1'b1; cmd_op_i = 4'b1001; cmd_addrC_i = AW'(6 + (i % 2));
      cmd_wdata_i = 16'hA001 + 16'(i);
    end
    @(negedge clk_i); cmd_v_i = 1'b0;
    n_chk++; if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL fifo_full ready=%b busy=%b exp ready=0 busy=1", cmd_ready_o, busy_o);
    end
    repeat (5) @(negedge clk_i);
    n_chk++; if (strobes != s0) begin n_fail++; $display("FAIL fifo_hold strobes=%0d exp=%0d", strobes, s0); end
    acc_if.acc_ready_i = 1'b1;
    send(4'b1001, 3'd0, 3'd0, 3'd7, 16'h0, 16'hA005);
    wait_idle(ok);
    n_chk++; if (wd_log.size() != 5) begin n_fail++; $display("FAIL fifo_count got=%0d exp=5", wd_log.size()); end
    for (int i = 0; i < 5; i++)
      if (i < wd_log.size()) begin
        n_chk++; if (wd_log[i] !== 16'hA001 + 16'(i)) begin
          n_fail++; $display("FAIL fifo_order%0d got=%h exp=%h", i, wd_log[i], 16'hA001 + 16'(i));
        end
      end
  endtask

  task automatic test_illegal();
    int s0;
    logic [VW-1:0] d;
    bit ok;
    n_chk++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL ill_pre got=%b exp=0", illegal_o); end
    s0 = strobes;
    send(4'b1111, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);
    send(4'b1000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);
    get_resp(d, ok);
    n_chk++; if (!ok || d !== 16'h1245) begin n_fail++; $display("FAIL ill_read got=%h ok=%0d exp=1245", d, ok); end
    n_chk++; if (illegal_o !== 1'b1) begin n_fail++; $display("FAIL ill_flag got=%b exp=1", illegal_o); end
    n_chk++; if (strobes - s0 != 1) begin n_fail++; $display("FAIL ill_strobes got=%0d exp=1", strobes - s0); end
  endtask

`ifdef VEC_ISSUE_TIMEOUT_EN
  task automatic test_timeout();
    logic [VW-1:0] d;
    bit ok;
    @(negedge clk_i); reset_n_i = 1'b0;
    @(negedge clk_i); reset_n_i = 1'b1; pend = 0;
    stuck = 1'b1;
    send(4'b1000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0);
    wait_strobe(ok);
    repeat (60) @(negedge clk_i);
    n_chk++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL to_early got=%b exp=0", illegal_o); end
    get_resp(d, ok);
    n_chk++; if (!ok || d !== 16'h0) begin n_fail++; $display("FAIL to_data got=%h ok=%0d exp=0", d, ok); end
    n_chk++; if (illegal_o !== 1'b1) begin n_fail++; $display("FAIL to_flag got=%b exp=1", illegal_o); end
    stuck = 1'b0; pend = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_vector_ops();
    test_scalar();
    test_fifo_full();
    test_illegal();
`ifdef VEC_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
